fifo_stream_reader: RTL and testbench

- Drain-side controller for the team's synchronous FIFO. It drives the FIFO read chip-select and read-enable, and absorbs the FIFO's one-cycle registered read latency.
- It presents the words as a valid/ready stream with packet framing (m_last every PKT_LEN beats).
- It sits between a syn_fifo instance and any downstream consumer that can stall.

---
 rtl/fifo_stream_reader.sv | 93 +++++++++
 tb/tb_fifo_stream_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a syn_fifo into a valid/ready stream with packet framing
// A 3-entry skid buffer absorbs the FIFO's one-cycle read latency so reads never depend on m_ready.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic                  busy
);

    localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] buf_mem [0:2];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            occ;
    logic                  inflight;
    logic [15:0]           beat_idx;
    logic                  issue;
    logic                  capture;
    logic                  pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Counting in-flight reads against the buffer space guarantees a slot for every returning word.
    assign issue      = enable & ~flush & ~fifo_empty &
                        (({1'b0, occ} + {2'b0, inflight}) < 3'd3);
    assign fifo_rd_en = issue;
    assign fifo_rd_cs = issue;

    assign m_valid = (occ != 2'd0);
    assign m_data  = m_valid ? buf_mem[rd_ptr] : '0;
    assign m_last  = m_valid & (beat_idx == LAST_IDX);
    assign busy    = m_valid | inflight;

    assign capture = inflight & ~flush;
    assign pop     = m_valid & m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            occ        <= 2'd0;
            inflight   <= 1'b0;
            beat_idx   <= 16'd0;
            beat_count <= '0;
        end else begin
            inflight <= issue;
            if (pop) begin
                beat_count <= beat_count + CNT_WIDTH'(1);
            end
            if (flush) begin
                wr_ptr   <= 2'd0;
                rd_ptr   <= 2'd0;
                occ      <= 2'd0;
                beat_idx <= 16'd0;
            end else begin
                if (capture) begin
                    buf_mem[wr_ptr] <= fifo_data;
                    wr_ptr          <= next_ptr(wr_ptr);
                end
                if (pop) begin
                    rd_ptr   <= next_ptr(rd_ptr);
                    beat_idx <= (beat_idx == LAST_IDX) ? 16'd0 : beat_idx + 16'd1;
                end
                case ({capture, pop})
                    2'b10:   occ <= occ + 2'd1;
                    2'b01:   occ <= occ - 2'd1;
                    default: occ <= occ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed bench for fifo_stream_reader with PKT_LEN=5
module tb_fifo_stream_reader;

    localparam int DW  = 8;
    localparam int PL  = 5;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_cs;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [CW-1:0] beat_count;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_cs(fifo_rd_cs), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .beat_count(beat_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Source FIFO model: registered data_out, one word popped per cycle with rd_en high.
    logic [DW-1:0] mem [0:1023];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rp        <= wp;
            fifo_data <= '0;
        end else if (fifo_rd_en) begin
            fifo_data <= mem[rp];
            rp        <= rp + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] exp_q[$];
    int idx      = 0;
    int out_cnt  = 0;
    int max_out  = 0;
    int n_acc    = 0;
    int last_cnt = 0;

    task automatic push(input logic [DW-1:0] d);
        mem[wp] = d;
        exp_q.push_back(d);
        wp = wp + 1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stream scoreboard: order, framing and outstanding-read bound.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            idx     = 0;
            out_cnt = 0;
        end else begin
            if (fifo_rd_en) out_cnt++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                    check("m_last", 32'(m_last), 32'(idx == PL - 1));
                end
                idx = (idx == PL - 1) ? 0 : idx + 1;
                n_acc++;
                out_cnt--;
                if (m_last) last_cnt++;
            end
            if (flush) begin
                idx     = 0;
                out_cnt = 0;
            end
            if (out_cnt > max_out) max_out = out_cnt;
        end
    end

    initial begin
        int first_hs;
        int last_hs;
        int rd_cnt;
        int lc0;
        int acc0;

        // Reset state
        #2;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_beat_count", 32'(beat_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step(2);
        rst = 1'b0;
        step(1);

        // 1: single word latency
        m_ready = 1'b1;
        push(8'hA5);
        enable = 1'b1;
        @(negedge clk);
        check("t1_rd_en_N", 32'(fifo_rd_en), 32'd1);
        check("t1_rd_cs_N", 32'(fifo_rd_cs), 32'd1);
        step(1);
        @(negedge clk);
        check("t1_rd_en_N1", 32'(fifo_rd_en), 32'd0);
        check("t1_valid_N1", 32'(m_valid), 32'd0);
        check("t1_busy_N1", 32'(busy), 32'd1);
        step(1);
        @(negedge clk);
        check("t1_valid_N2", 32'(m_valid), 32'd1);
        check("t1_data_N2", 32'(m_data), 32'hA5);
        step(1);
        @(negedge clk);
        check("t1_beat_count", 32'(beat_count), 32'd1);
        check("t1_busy_idle", 32'(busy), 32'd0);
        step(1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;

        // 2: 20 back-to-back words, last on 0x04,0x09,0x0E,0x13
        lc0 = last_cnt;
        for (int i = 0; i < 20; i++) push(8'(i));
        first_hs = -1;
        last_hs  = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                if (first_hs < 0) first_hs = c;
                last_hs = c;
            end
            step(1);
        end
        check("t2_span", 32'(last_hs - first_hs), 32'd19);
        check("t2_last_cnt", 32'(last_cnt - lc0), 32'd4);
        check("t2_beat_count", 32'(beat_count), 32'd21);

        // 3: backpressure
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(8'hB0 + 8'(i));
        rd_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_cnt++;
            if (c == 3) check("t3_head_early", 32'(m_data), 32'hB0);
            step(1);
        end
        check("t3_reads", 32'(rd_cnt), 32'd3);
        check("t3_valid", 32'(m_valid), 32'd1);
        check("t3_head", 32'(m_data), 32'hB0);
        acc0 = n_acc;
        m_ready = 1'b1;
        step(25);
        check("t3_accepted", 32'(n_acc - acc0), 32'd10);
        check("t3_beat_count", 32'(beat_count), 32'd31);
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // 4: random ready and fill
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        max_out = 0;
        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 1) == 1) push(8'(c));
            m_ready = ($urandom_range(0, 1) == 1);
            step(1);
        end
        m_ready = 1'b1;
        step(20);
        check("t4_drained", 32'(exp_q.size()), 32'd0);
        check("t4_max_out", 32'(max_out <= 3), 32'd1);
        check("t4_beat_count", 32'(beat_count), 32'(n_acc));

        // 5: flush with 2 buffered and 1 in flight
        m_ready = 1'b0;
        enable  = 1'b0;
        step(1);
        for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
        enable = 1'b1;
        step(3);
        flush = 1'b1;
        acc0 = n_acc;
        step(1);
        flush = 1'b0;
        @(negedge clk);
        check("t5_valid_after_flush", 32'(m_valid), 32'd0);
        check("t5_beat_count_kept", 32'(beat_count), 32'(acc0));
        for (int i = 0; i < 3; i++) void'(exp_q.pop_front());
        lc0 = last_cnt;
        for (int i = 6; i < 10; i++) push(8'hC0 + 8'(i));
        m_ready = 1'b1;
        step(20);
        check("t5_accepted", 32'(n_acc - acc0), 32'd7);
        check("t5_last_cnt", 32'(last_cnt - lc0), 32'd1);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 10; i++) push(8'hD0 + 8'(i));
        step(4);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(m_valid), 32'd0);
        check("t6_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t6_data", 32'(m_data), 32'd0);
        check("t6_beat_count", 32'(beat_count), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        step(2);
        rst = 1'b0;
        step(1);
        for (int i = 0; i < 3; i++) push(8'hE0 + 8'(i));
        step(10);
        check("t6_restart_count", 32'(beat_count), 32'd3);
        check("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
